// File: rtl/if_id_pkg.sv
// Shared defaults and the queue entry layout for the IF/ID instruction queue.
package if_id_pkg;

  localparam int IFQ_DEPTH = 4;
  localparam int PC_W      = 32;
  localparam int INST_W    = 32;

  localparam logic [INST_W-1:0] NOP_INSTR = 32'd0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instruction;
  } ifq_entry_t;

endpackage

// File: rtl/if_queue_ram.sv
// Storage array for the IF/ID queue.
// Synchronous write, asynchronous read. The array has no reset because the
// valid state is tracked by the queue's occupancy counter.
module if_queue_ram
  import if_id_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int DATA_W = PC_W + INST_W
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write the addressed slot on an accepted push.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode.
// Buffers {pc, instruction} pairs so fetch keeps running while decode stalls.
// A taken branch (i_flush) empties the queue; o_full freezes the fetch PC.
// Optional build macro: IFQ_BYPASS_EN -- an empty queue with a push and a pop
// in the same cycle forwards the fetched word straight to the head outputs.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int PC_W   = if_id_pkg::PC_W,
  parameter int INST_W = if_id_pkg::INST_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ready,
  input  logic                     i_flush,
  input  logic                     i_push_valid,
  input  logic [PC_W-1:0]          i_push_pc,
  input  logic [INST_W-1:0]        i_push_instruction,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_out_valid,
  output logic [PC_W-1:0]          o_out_pc,
  output logic [INST_W-1:0]        o_out_instruction,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = PC_W + INST_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_stored_valid;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic              w_bypass;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_data;
  logic [PC_W-1:0]   w_head_pc;
  logic [INST_W-1:0] w_head_inst;

  // Status flags come from registered occupancy only, so pop never loops into full.
  assign w_full         = (r_count == FULL_CNT);
  assign w_stored_valid = (r_count != '0);

  assign w_pop_ok  = i_ready & i_pop & w_stored_valid;
  assign w_push_ok = i_ready & i_push_valid & ~i_flush & (~w_full | w_pop_ok);

`ifdef IFQ_BYPASS_EN
  // Empty queue consumed in the same cycle: forward instead of storing.
  assign w_bypass = ~w_stored_valid & w_push_ok & i_pop;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr_en = w_push_ok & ~w_bypass;

  if_queue_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({i_push_pc, i_push_instruction}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign w_head_pc   = w_rd_data[DATA_W-1:INST_W];
  assign w_head_inst = w_rd_data[INST_W-1:0];

  // Pointer and occupancy update; reset beats flush, flush beats a memory stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_ready) begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_wr_en && !w_pop_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr_en && w_pop_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Head outputs: forwarded word, stored head, or zero/NOP when nothing is valid.
  always_comb begin
    o_out_valid       = w_stored_valid;
    o_out_pc          = '0;
    o_out_instruction = INST_W'(NOP_INSTR);
    if (w_bypass) begin
      o_out_valid       = 1'b1;
      o_out_pc          = i_push_pc;
      o_out_instruction = i_push_instruction;
    end else if (w_stored_valid) begin
      o_out_pc          = w_head_pc;
      o_out_instruction = w_head_inst;
    end
  end

  assign o_full  = w_full;
  assign o_count = r_count;

endmodule
